// File: rtl/track_uart_dump_pkg.sv
// ============================================================================
// Module   : track_dump_pkg
// Brief    : Shared FSM state encoding and UART framing constants for the
//            track memory UART exporter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package track_dump_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5,
    CHK   = 3'd6,
    DONE  = 3'd7
  } state_e;

  localparam logic UART_IDLE            = 1'b1;
  localparam int   FRAME_BITS           = 10;
  localparam int   DEFAULT_CLKS_PER_BIT = 868;

endpackage

`default_nettype wire

// File: rtl/track_uart_dump_if.sv
// ============================================================================
// Module   : track_uart_dump_if
// Brief    : Request, track memory read port and UART line of the exporter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface track_uart_dump_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) ();

  logic              dump;
  logic [ADDR_W-1:0] limit;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              tx;

  modport master (
    input  dump, limit, rd_data,
    output rd_addr, busy, done, tx
  );

  modport slave (
    output dump, limit, rd_data,
    input  rd_addr, busy, done, tx
  );

endinterface

`default_nettype wire

// File: rtl/track_uart_dump_uart_tx_byte.sv
// ============================================================================
// Module   : uart_tx_byte
// Brief    : 8N1 byte serialiser with baud counter; accepts a byte on go while
//            ready, including back-to-back in the last stop-bit cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_byte
  import track_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  wire logic       clock,
  input  wire logic       reset,
  input  wire logic       go,
  input  wire logic [7:0] byte_in,
  output logic            ready,
  output logic            tx
);

  localparam int             CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BIT = 3'(FRAME_BITS - 3);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  assign ready = (state_q == IDLE) || ((state_q == STOP) && (cnt_q == '0));
  assign tx    = tx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Counter reloads on every state entry so bit edges never accumulate drift.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = CNT_LAST;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_LAST;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = UART_IDLE;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
    if (go && ready) begin
      state_d = START;
      cnt_d   = CNT_LAST;
      shift_d = byte_in;
      tx_d    = ~UART_IDLE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/track_uart_dump.sv
// ============================================================================
// Module   : track_uart_dump
// Brief    : Reads a track memory from address 0 to limit-1 on dump and sends
//            each note as an 8N1 UART frame. Build option
//            TRACK_DUMP_CHECKSUM_EN appends an XOR checksum frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module track_uart_dump
  import track_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 8
) (
  input wire logic         clock,
  input wire logic         reset,
  track_uart_dump_if.master bus
);

`ifdef TRACK_DUMP_CHECKSUM_EN
  localparam state_e TAIL_STATE = CHK;
`else
  localparam state_e TAIL_STATE = DONE;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] limit_q, limit_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   addr_nxt;
  logic              more_notes;
  logic              chk_done;
  logic              tx_go;
  logic [DATA_W-1:0] tx_byte;
  logic              tx_ready;
  logic              tx_line;

  // Widened compare: a limit of 2^ADDR_W-1 ends cleanly without wrapping.
  assign addr_nxt   = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign more_notes = addr_nxt < {1'b0, limit_q};

`ifdef TRACK_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d;
  logic              chk_sent_q, chk_sent_d;

  assign chk_done = chk_sent_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      chk_q      <= '0;
      chk_sent_q <= 1'b0;
    end else begin
      chk_q      <= chk_d;
      chk_sent_q <= chk_sent_d;
    end
  end
`else
  assign chk_done = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      limit_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      limit_q <= limit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    limit_d = limit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_go   = 1'b0;
    tx_byte = bus.rd_data;
`ifdef TRACK_DUMP_CHECKSUM_EN
    chk_d      = chk_q;
    chk_sent_d = chk_sent_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.dump) begin
          state_d = FETCH;
          addr_d  = '0;
          limit_d = bus.limit;
          busy_d  = 1'b1;
`ifdef TRACK_DUMP_CHECKSUM_EN
          chk_d      = '0;
          chk_sent_d = 1'b0;
`endif
        end
      end
      FETCH: state_d = (limit_q == '0) ? TAIL_STATE : LOAD;
      LOAD: begin
        tx_go   = 1'b1;
        state_d = STOP;
`ifdef TRACK_DUMP_CHECKSUM_EN
        chk_d = chk_q ^ bus.rd_data;
`endif
      end
      // The serialiser sequences start/data/stop; STOP here waits for it.
      STOP: begin
        if (tx_ready) begin
          if (chk_done) begin
            state_d = DONE;
          end else if (more_notes) begin
            addr_d  = addr_nxt[ADDR_W-1:0];
            state_d = FETCH;
          end else begin
            state_d = TAIL_STATE;
          end
        end
      end
`ifdef TRACK_DUMP_CHECKSUM_EN
      CHK: begin
        tx_go      = 1'b1;
        tx_byte    = chk_q;
        chk_sent_d = 1'b1;
        state_d    = STOP;
      end
`endif
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clock   (clock),
    .reset   (reset),
    .go      (tx_go),
    .byte_in (tx_byte[7:0]),
    .ready   (tx_ready),
    .tx      (tx_line)
  );

  assign bus.rd_addr = addr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.tx      = tx_line;

endmodule

`default_nettype wire

// File: tb/tb_track_uart_dump.sv
// ============================================================================
// Module   : tb_track_uart_dump
// Brief    : Self-checking bench for track_uart_dump: decodes the UART line
//            and compares frames and timing with a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_track_uart_dump;

  localparam int C  = 4;
  localparam int FR = 10 * C + 2;

  typedef struct {
    int lim;
    int kind;
    int dump2_at;
    int exp_done;
    int exp_frames;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  track_uart_dump_if #(.ADDR_W(6), .DATA_W(8)) bus ();

  track_uart_dump #(
    .CLKS_PER_BIT (C),
    .ADDR_W       (6),
    .DATA_W       (8)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.master)
  );

  logic [7:0] mem [64];
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Timing model, labels counted from the edge that samples dump (label 1 = first cycle after it).
  function automatic int model_tail(input int lim);
    return (lim == 0) ? 3 : 2 + lim * FR;
  endfunction

  function automatic int model_done(input int lim);
`ifdef TRACK_DUMP_CHECKSUM_EN
    return model_tail(lim) + 10 * C + 1;
`else
    return model_tail(lim);
`endif
  endfunction

  function automatic int model_frames(input int lim);
`ifdef TRACK_DUMP_CHECKSUM_EN
    return lim + 1;
`else
    return lim;
`endif
  endfunction

  task automatic fill_mem(input int kind);
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0:       mem[i] = (i < 3) ? 8'(1 << i) : 8'h00;
        1:       mem[i] = 8'(i);
        default: mem[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic run_case(input int lim, input int dump2_at, input int exp_done, input int exp_frames);
    bit txq[$];
    int exp_b[$];
    int exp_s[$];
    int got_b[$];
    int got_s[$];
    int x, budget, done_cnt, done_at, max_addr, busy_prev, busy_at_done, busy_before_done;
    int i, b, n;
    bit ok;
    x = 0; done_cnt = 0; done_at = -1; max_addr = 0;
    busy_prev = 0; busy_at_done = -1; busy_before_done = -1;
    for (int k = 0; k < lim; k++) begin
      exp_b.push_back(int'(mem[k]));
      exp_s.push_back(3 + k * FR);
      x = x ^ int'(mem[k]);
    end
`ifdef TRACK_DUMP_CHECKSUM_EN
    exp_b.push_back(x);
    exp_s.push_back(model_tail(lim));
`endif
    budget = exp_done + 10 * C + 10;

    @(negedge clk);
    bus.limit = 6'(lim);
    bus.dump  = 1'b1;
    @(posedge clk); #1;
    bus.dump = 1'b0;
    for (int lab = 1; lab <= budget; lab++) begin
      if (lab > 1) begin
        @(posedge clk); #1;
      end
      if (dump2_at > 0) bus.dump = (lab == dump2_at);
      if (lab == 1) begin
        check("busy_rise", int'(bus.busy), 1);
        check("addr_first", int'(bus.rd_addr), 0);
      end
      txq.push_back(bus.tx);
      if (int'(bus.rd_addr) > max_addr) max_addr = int'(bus.rd_addr);
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at          = lab;
          busy_at_done     = int'(bus.busy);
          busy_before_done = busy_prev;
        end
      end
      busy_prev = int'(bus.busy);
    end
    bus.dump = 1'b0;

    // Decode 8N1 frames from the recorded line, sampling mid-bit.
    i = 0;
    while (i < txq.size()) begin
      if (txq[i] == 1'b0) begin
        got_s.push_back(i + 1);
        if (i + C / 2 + 9 * C >= txq.size()) begin
          got_b.push_back(-1);
          break;
        end
        ok = (txq[i + C / 2] == 1'b0) && (txq[i + C / 2 + 9 * C] == 1'b1);
        b = 0;
        for (int k = 0; k < 8; k++) if (txq[i + C / 2 + (k + 1) * C]) b = b | (1 << k);
        got_b.push_back(ok ? b : -2);
        i = i + 10 * C;
      end else begin
        i++;
      end
    end

    check("frame_count", got_b.size(), exp_frames);
    n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("frame%0d_byte", k), got_b[k], exp_b[k]);
      check($sformatf("frame%0d_start", k), got_s[k], exp_s[k]);
    end
    check("done_count", done_cnt, 1);
    check("done_cycle", done_at, exp_done);
    check("busy_at_done", busy_at_done, 0);
    check("busy_before_done", busy_before_done, 1);
    check("max_rd_addr", max_addr, (lim == 0) ? 0 : lim - 1);
  endtask

  vec_t tbl[6];

  initial begin
    int lows, dones, rl;
    rst       = 1'b1;
    bus.dump  = 1'b0;
    bus.limit = '0;
    fill_mem(0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", int'(bus.tx), 1);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_rd_addr", int'(bus.rd_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    rl = $urandom_range(2, 8);
    tbl[0] = '{3,  0, 0,  model_done(3),  model_frames(3)};
    tbl[1] = '{0,  0, 0,  model_done(0),  model_frames(0)};
    tbl[2] = '{3,  0, 50, model_done(3),  model_frames(3)};
    tbl[3] = '{1,  2, 0,  model_done(1),  model_frames(1)};
    tbl[4] = '{rl, 2, 0,  model_done(rl), model_frames(rl)};
    tbl[5] = '{63, 1, 0,  model_done(63), model_frames(63)};

    foreach (tbl[v]) begin
      fill_mem(tbl[v].kind);
      run_case(tbl[v].lim, tbl[v].dump2_at, tbl[v].exp_done, tbl[v].exp_frames);
      repeat (5) @(posedge clk);
    end

    // Reset during data bit 3 of the first frame (0x01, so the line is low there).
    fill_mem(0);
    @(negedge clk);
    bus.limit = 6'd3;
    bus.dump  = 1'b1;
    @(posedge clk); #1;
    bus.dump = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("mid_frame_low", int'(bus.tx), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_tx", int'(bus.tx), 1);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_rd_addr", int'(bus.rd_addr), 0);
    rst = 1'b0;
    lows = 0;
    dones = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (bus.tx == 1'b0) lows++;
      if (bus.done) dones++;
    end
    check("no_resume_low", lows, 0);
    check("no_resume_done", dones, 0);
    run_case(3, 0, model_done(3), model_frames(3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
